fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage pipeline. Owns the program counter, drives the word address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. Handles load-use stalls from the hazard unit, redirects from later stages, and zero-penalty resolution of JUMP in fetch. Provides a retired-fetch counter for debug.

## Interface
- `PC_W`, 32: program-counter width. The PC is a word index; memory address = PC.
- `RESET_PC`, 0: PC value after reset.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- imem_pc  out  PC_W  word address to instruction memory.
- imem_instr  in  32  instruction word for imem_pc, combinational, same cycle.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- redirect_valid  in  1  later stage requests a PC change.
- redirect_pc  in  PC_W  target when redirect_valid.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  32  captured instruction; NOP_INSTR when invalid.
- ifid_pc  out  PC_W  PC of the captured instruction.
- ifid_pc_plus1  out  PC_W  ifid_pc + 1, modulo 2^PC_W.
- fetch_count  out  32  number of valid instructions captured into IF/ID.

## Operation
- Encoding: op = instr[31:26]. JUMP uses op 000000, with the target in instr[25:0]. The all-zero word is JUMP 0.
- The bubble is NOP_INSTR = 32'h0400_0000, which encodes ADD R0 R0 R0. Zero is never used as a bubble.
- imem_pc is driven directly from the PC register, so no combinational path runs from the inputs to imem_pc.
- Next-state priority is evaluated once per cycle, highest first:
  1. **redirect_valid**: PC ← redirect_pc. IF/ID is flushed (valid=0, instr=NOP_INSTR, pc fields hold their last value). This wins over stall, because the redirecting instruction is older than any stalled one.
  2. **stall**: PC, IF/ID and fetch_count all hold.
  3. **JUMP in fetch** (imem_instr[31:26]==OP_JUMP): PC ← {PC[PC_W-1:26], imem_instr[25:0]}. The jump is consumed in fetch: IF/ID ← invalid bubble and fetch_count does not change.
  4. **sequential**: PC ← PC+1 (wraps 2^PC_W−1 → 0). IF/ID ← {valid=1, instr=imem_instr, pc=PC, pc_plus1=PC+1}. fetch_count increments (wraps 2^32−1 → 0).
- Reset values:
  - PC = RESET_PC.
  - ifid_valid = 0, ifid_instr = NOP_INSTR, ifid_pc = 0, ifid_pc_plus1 = 0.
  - fetch_count = 0.
- Reset asserted mid-stall or mid-redirect overrides everything immediately, because it is asynchronous.
- The first fetch after reset release is from RESET_PC, on the first rising edge with rst low.

## Timing
- Fetch latency: the instruction at address P appears on ifid_* one cycle after imem_pc==P.
- Sequential code sustains one instruction per cycle.
- Jump penalty is 0 cycles: the target address is on imem_pc in the cycle after the jump was on imem_instr. One bubble enters IF/ID in place of the jump.
- Redirect penalty:
  - Only the IF/ID content is squashed.
  - redirect_pc is on imem_pc in the cycle after redirect_valid.
  - The first valid target instruction is on ifid_* one cycle later.
- Stall is level-sensitive. N stall cycles produce exactly N cycles of hold with identical outputs, with no lost or duplicated fetch.
- A redirect that arrives during a stall: the redirect takes effect, and the stall is ignored for that cycle only.

## Structure
- Add to def.v:
  - `OP_JUMP` = 6'b000000
  - `OP_ADD` = 6'b000001
  - `OP_LW` = 6'b010000
  - `NOP_INSTR` = 32'h0400_0000
  - `RESET_PC` default
- Sub-module `fetch_ifid_reg` holds the IF/ID register and its valid bit. Its inputs are load, flush and the data fields. Flush has priority over load.
- The PC register, the next-PC mux and fetch_count live in `fetch_stage`.

## Test plan
- **Reset, then run from 0** through ADD, ADD, ADD (words 0–2):
  - ifid_pc reads 0, 1, 2 on consecutive cycles, with ifid_valid=1 each cycle.
  - fetch_count = 3 after the third capture.
- **stall held for 2 cycles while imem_pc=5** (LW at 5, ADD at 6):
  - imem_pc stays 5 for 2 cycles, and the ifid_* outputs stay frozen.
  - After release, ifid_pc=5 then 6, with no duplicate capture.
- **Word 12 = 32'h0000_0000** (JUMP 0):
  - The next cycle has imem_pc=0, ifid_valid=0 and ifid_instr=32'h0400_0000.
  - fetch_count is unchanged.
- **redirect_valid with redirect_pc=8, asserted together with stall**:
  - The next cycle has imem_pc=8 and ifid_valid=0.
  - The following cycle has ifid_pc=8 and ifid_valid=1.
- **Wrap-around**: with RESET_PC=32'hFFFF_FFFF and a non-jump word returned:
  - The next cycle has imem_pc=0, ifid_pc=32'hFFFF_FFFF and ifid_pc_plus1=0.
- **Assert rst asynchronously, between clock edges, in the middle of a sequence**:
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared opcodes, bubble encoding and reset defaults for the fetch stage.
package fetch_stage_pkg;

    localparam logic [5:0]  OP_JUMP   = 6'b000000;
    localparam logic [5:0]  OP_ADD    = 6'b000001;
    localparam logic [5:0]  OP_LW     = 6'b010000;

    // ADD R0 R0 R0; the all-zero word is JUMP 0, so it can never be the bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0400_0000;

    localparam int unsigned PC_W_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic is_jump(input logic [31:0] instr);
        return instr[31:26] == OP_JUMP;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard/redirect inputs and IF/ID outputs.
interface fetch_stage_if #(
    parameter int unsigned PC_W = 32
);
    logic [PC_W-1:0] imem_pc;
    logic [31:0]     imem_instr;
    logic            stall;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            ifid_valid;
    logic [31:0]     ifid_instr;
    logic [PC_W-1:0] ifid_pc;
    logic [PC_W-1:0] ifid_pc_plus1;
    logic [31:0]     fetch_count;

    // The fetch stage itself.
    modport master (
        output imem_pc, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus1, fetch_count,
        input  imem_instr, stall, redirect_valid, redirect_pc
    );

    // Memory, hazard unit and downstream stages.
    modport slave (
        input  imem_pc, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus1, fetch_count,
        output imem_instr, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register with valid bit; flush beats load, neither means hold.
module fetch_ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [31:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] pc_plus1_i,
    output logic            valid_o,
    output logic [31:0]     instr_o,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_plus1_o
);

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus1_q, pc_plus1_d;

    // Next-state: a flush leaves the PC fields as they were.
    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus1_d = pc_plus1_q;
        if (flush_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load_i) begin
            valid_d    = 1'b1;
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus1_d = pc_plus1_i;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus1_q <= '0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus1_q <= pc_plus1_d;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus1_o = pc_plus1_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC priority mux, in-fetch JUMP and fetch counter.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] jump_pc;
    logic [31:0]     count_q, count_d;
    logic            jump;
    logic            capture;
    logic            ifid_flush;

    assign pc_plus1 = pc_q + PC_W'(1);
    assign jump     = is_jump(bus.imem_instr);

    // Jump target replaces only the low 26 bits; upper PC bits are kept.
    always_comb begin
        jump_pc       = pc_q;
        jump_pc[25:0] = bus.imem_instr[25:0];
    end

    // Next-PC priority: redirect, stall, jump, sequential.
    always_comb begin
        pc_d       = pc_plus1;
        capture    = 1'b0;
        ifid_flush = 1'b0;
        if (bus.redirect_valid) begin
            pc_d       = bus.redirect_pc;
            ifid_flush = 1'b1;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (jump) begin
            pc_d       = jump_pc;
            ifid_flush = 1'b1;
        end else begin
            capture = 1'b1;
        end
        count_d = capture ? count_q + 32'd1 : count_q;
    end

    // PC and fetch counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    assign bus.imem_pc     = pc_q;
    assign bus.fetch_count = count_q;

    fetch_ifid_reg #(
        .PC_W (PC_W)
    ) u_ifid (
        .clk        (clk),
        .rst        (rst),
        .load_i     (capture),
        .flush_i    (ifid_flush),
        .instr_i    (bus.imem_instr),
        .pc_i       (pc_q),
        .pc_plus1_i (pc_plus1),
        .valid_o    (bus.ifid_valid),
        .instr_o    (bus.ifid_instr),
        .pc_o       (bus.ifid_pc),
        .pc_plus1_o (bus.ifid_pc_plus1)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus async-reset and PC-wrap sequences.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0400_0000;

    logic clk;
    logic rst;

    fetch_stage_if #(.PC_W(32)) bus ();
    fetch_stage_if #(.PC_W(32)) bus_w ();

    fetch_stage #(
        .PC_W     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_stage #(
        .PC_W     (32),
        .RESET_PC (32'hFFFF_FFFF)
    ) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    // Program: ADDs everywhere, LW at 5, JUMP 0 (all-zero word) at 12.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd5)  return 32'h4000_0005;
        if (a == 32'd12) return 32'h0000_0000;
        return 32'h0400_1000 + {20'h0, a[11:0]};
    endfunction

    assign bus.imem_instr   = mem_word(bus.imem_pc);
    assign bus_w.imem_instr = 32'h0400_0001;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] e_imem;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                                input logic [31:0] im, input logic v,
                                input logic [31:0] pc, input logic [31:0] cnt);
        vec_t x;
        x.stall = s; x.redir = r; x.rpc = rp;
        x.e_imem = im; x.e_valid = v; x.e_pc = pc; x.e_cnt = cnt;
        return x;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, " imem_pc"},   bus.imem_pc, 32'd0);
        chk({tag, " valid"},     {31'd0, bus.ifid_valid}, 32'd0);
        chk({tag, " instr"},     bus.ifid_instr, NOP);
        chk({tag, " pc"},        bus.ifid_pc, 32'd0);
        chk({tag, " pc_plus1"},  bus.ifid_pc_plus1, 32'd0);
        chk({tag, " count"},     bus.fetch_count, 32'd0);
        chk({tag, " w imem_pc"}, bus_w.imem_pc, 32'hFFFF_FFFF);
    endtask

    task automatic chk_wrap(input string tag);
        chk({tag, " w imem_pc"},  bus_w.imem_pc, 32'd0);
        chk({tag, " w valid"},    {31'd0, bus_w.ifid_valid}, 32'd1);
        chk({tag, " w pc"},       bus_w.ifid_pc, 32'hFFFF_FFFF);
        chk({tag, " w pc_plus1"}, bus_w.ifid_pc_plus1, 32'd0);
    endtask

    initial begin
        //               stall redir rpc  imem v  pc  cnt
        vecs.push_back(mk(0, 0, 0,  1, 1,  0,  1));
        vecs.push_back(mk(0, 0, 0,  2, 1,  1,  2));
        vecs.push_back(mk(0, 0, 0,  3, 1,  2,  3));
        vecs.push_back(mk(0, 0, 0,  4, 1,  3,  4));
        vecs.push_back(mk(0, 0, 0,  5, 1,  4,  5));
        vecs.push_back(mk(1, 0, 0,  5, 1,  4,  5));   // stall with imem_pc=5
        vecs.push_back(mk(1, 0, 0,  5, 1,  4,  5));
        vecs.push_back(mk(0, 0, 0,  6, 1,  5,  6));   // LW captured once
        vecs.push_back(mk(0, 0, 0,  7, 1,  6,  7));
        vecs.push_back(mk(0, 0, 0,  8, 1,  7,  8));
        vecs.push_back(mk(0, 0, 0,  9, 1,  8,  9));
        vecs.push_back(mk(0, 0, 0, 10, 1,  9, 10));
        vecs.push_back(mk(0, 0, 0, 11, 1, 10, 11));
        vecs.push_back(mk(0, 0, 0, 12, 1, 11, 12));
        vecs.push_back(mk(0, 0, 0,  0, 0, 11, 12));   // JUMP 0 consumed in fetch
        vecs.push_back(mk(0, 0, 0,  1, 1,  0, 13));
        vecs.push_back(mk(1, 1, 8,  8, 0,  0, 13));   // redirect beats stall
        vecs.push_back(mk(0, 0, 0,  9, 1,  8, 14));
        vecs.push_back(mk(0, 1, 12, 12, 0, 8, 14));   // redirect onto the jump word
        vecs.push_back(mk(0, 0, 0,  0, 0,  8, 14));
        vecs.push_back(mk(0, 0, 0,  1, 1,  0, 15));

        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus_w.stall = 1'b0;
        bus_w.redirect_valid = 1'b0;
        bus_w.redirect_pc = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.stall          = vecs[i].stall;
            bus.redirect_valid = vecs[i].redir;
            bus.redirect_pc    = vecs[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d imem_pc", i), bus.imem_pc, vecs[i].e_imem);
            chk($sformatf("v%0d valid", i), {31'd0, bus.ifid_valid},
                {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d pc", i), bus.ifid_pc, vecs[i].e_pc);
            chk($sformatf("v%0d pc_plus1", i), bus.ifid_pc_plus1, vecs[i].e_pc + 32'd1);
            chk($sformatf("v%0d instr", i), bus.ifid_instr,
                vecs[i].e_valid ? mem_word(vecs[i].e_pc) : NOP);
            chk($sformatf("v%0d count", i), bus.fetch_count, vecs[i].e_cnt);
            if (i == 0) chk_wrap("wrap");
        end

        // Async reset between edges, mid-sequence.
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk_reset("async");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("restart imem_pc", bus.imem_pc, 32'd1);
        chk("restart valid", {31'd0, bus.ifid_valid}, 32'd1);
        chk("restart pc", bus.ifid_pc, 32'd0);
        chk("restart instr", bus.ifid_instr, mem_word(32'd0));
        chk("restart count", bus.fetch_count, 32'd1);
        chk_wrap("rewrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
